// File: rtl/dekatron_seek_ctrl_if.sv
// Host and counter-side signals of the dekatron seek controller, bundled for one port.
// Handshake: CntRequest pulses for one cycle only while CntReady=1; the counter then drops CntReady, and raising it again marks completion.
interface dekatron_seek_ctrl_if #(
    parameter int D_NUM = 6
);
    logic                 Start;
    logic                 Load;
    logic                 Abort;
    logic [D_NUM*4-1:0]   Target;
    logic [D_NUM*4-1:0]   CntOut;
    logic                 CntReady;
    logic                 CntRequest;
    logic                 CntDec;
    logic                 CntSet;
    logic [D_NUM*4-1:0]   CntIn;
    logic                 Busy;
    logic                 Done;
    logic [15:0]          StepCount;

    // master = environment (host plus counter), slave = the controller
    modport master (
        output Start, Load, Abort, Target, CntOut, CntReady,
        input  CntRequest, CntDec, CntSet, CntIn, Busy, Done, StepCount
    );

    modport slave (
        input  Start, Load, Abort, Target, CntOut, CntReady,
        output CntRequest, CntDec, CntSet, CntIn, Busy, Done, StepCount
    );
endinterface

// File: rtl/dekatron_seek_ctrl.sv
// Drives a BCD dekatron counter to a target value, either by a direct load
// or by single-step increments/decrements, one counter handshake per step.
module dekatron_seek_ctrl #(
    parameter int D_NUM = 6
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    dekatron_seek_ctrl_if.slave   bus,
    output logic [2:0]            dbg_state
);
    localparam int W = D_NUM * 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COMPARE   = 3'd1,
        ISSUE     = 3'd2,
        WAIT_ACK  = 3'd3,
        WAIT_DONE = 3'd4,
        FINISH    = 3'd5
    } state_t;

    state_t         state, state_n;
    logic [W-1:0]   target_q;
    logic           load_q;
    logic           abort_q;
    logic           dec_q;
    logic           set_q;
    logic [15:0]    step_cnt;
    logic           req;
    logic           abort_seen;

    assign abort_seen = abort_q | bus.Abort;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        req     = 1'b0;
        case (state)
            IDLE:      if (bus.Start) state_n = COMPARE;
            COMPARE: begin
                if (load_q)                      state_n = ISSUE;
                else if (bus.CntOut == target_q) state_n = FINISH;
                else                             state_n = ISSUE;
            end
            ISSUE: begin
                if (bus.CntReady) begin
                    req     = 1'b1;
                    state_n = WAIT_ACK;
                end
            end
            WAIT_ACK:  if (!bus.CntReady) state_n = WAIT_DONE;
            WAIT_DONE: begin
                if (bus.CntReady) begin
                    if (load_q)          state_n = FINISH;
                    else if (abort_seen) state_n = IDLE;
                    else                 state_n = COMPARE;
                end
            end
            FINISH:    state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            target_q <= '0;
            load_q   <= 1'b0;
            abort_q  <= 1'b0;
            dec_q    <= 1'b0;
            set_q    <= 1'b0;
            step_cnt <= '0;
        end else begin
            if (state == IDLE && bus.Start) begin
                target_q <= bus.Target;
                load_q   <= bus.Load;
                abort_q  <= 1'b0;
                set_q    <= 1'b0;
                step_cnt <= '0;
            end else if (state != IDLE && bus.Abort) begin
                abort_q <= 1'b1;
            end

            // Direction is decided once per step and held through the handshake
            if (state == COMPARE) begin
                if (load_q) set_q <= 1'b1;
                else        dec_q <= (bus.CntOut > target_q);
            end

            if (req && !load_q && step_cnt != 16'hFFFF)
                step_cnt <= step_cnt + 16'd1;

            if (state == FINISH)
                set_q <= 1'b0;
        end
    end

    assign bus.CntRequest = req;
    assign bus.CntDec     = dec_q;
    assign bus.CntSet     = set_q;
    assign bus.CntIn      = target_q;
    assign bus.Busy       = (state != IDLE);
    assign bus.Done       = (state == FINISH) && !abort_seen;
    assign bus.StepCount  = step_cnt;
    assign dbg_state      = state;
endmodule

// File: tb/tb_dekatron_seek_ctrl.sv
// Bench for dekatron_seek_ctrl: behavioural BCD counter responder, vector table of
// complete operations, and directed abort / busy-start / mid-handshake reset sequences.
module tb_dekatron_seek_ctrl;
    localparam int D_NUM = 6;
    localparam int W     = D_NUM * 4;

    logic        Clk;
    logic        Rst_n;
    logic [2:0]  dbg_state;

    dekatron_seek_ctrl_if #(.D_NUM(D_NUM)) bus ();

    dekatron_seek_ctrl #(.D_NUM(D_NUM)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int req_cnt, dec_cnt, set_cnt, done_cnt, done_cyc, start_cyc;

    typedef struct {
        string        name;
        logic         load;
        logic [W-1:0] cnt0;
        logic [W-1:0] target;
        int           exp_req;
        logic         exp_dec;
        logic [W-1:0] exp_cnt;
    } vec_t;

    vec_t vecs[7];

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int d = 0; d < D_NUM; d++) begin
            if (c) begin
                if (r[d*4+:4] == 4'd9) r[d*4+:4] = 4'd0;
                else begin
                    r[d*4+:4] = r[d*4+:4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        r = v;
        b = 1'b1;
        for (int d = 0; d < D_NUM; d++) begin
            if (b) begin
                if (r[d*4+:4] == 4'd0) r[d*4+:4] = 4'd9;
                else begin
                    r[d*4+:4] = r[d*4+:4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Counter model: drops CntReady after a request, applies it after a random latency
    initial begin : responder
        logic         r_set, r_dec;
        logic [W-1:0] r_in;
        int           lat;
        forever begin
            @(negedge Clk);
            if (bus.CntRequest === 1'b1 && Rst_n === 1'b1) begin
                r_set = bus.CntSet;
                r_dec = bus.CntDec;
                r_in  = bus.CntIn;
                lat   = $urandom_range(1, 3);
                @(posedge Clk);
                #1 bus.CntReady = 1'b0;
                repeat (lat) @(posedge Clk);
                #1;
                if (Rst_n === 1'b1) chk("dec_hold", {31'd0, bus.CntDec}, {31'd0, r_dec});
                if (r_set)      bus.CntOut = r_in;
                else if (r_dec) bus.CntOut = bcd_dec(bus.CntOut);
                else            bus.CntOut = bcd_inc(bus.CntOut);
                bus.CntReady = 1'b1;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge Clk);
            if (bus.CntRequest === 1'b1) begin
                req_cnt++;
                if (bus.CntDec === 1'b1) dec_cnt++;
                if (bus.CntSet === 1'b1) set_cnt++;
            end
            if (bus.Done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic clear_counts();
        req_cnt  = 0;
        dec_cnt  = 0;
        set_cnt  = 0;
        done_cnt = 0;
        done_cyc = -1;
    endtask

    task automatic start_op(input logic load, input logic [W-1:0] target);
        clear_counts();
        start_cyc  = cyc;
        bus.Start  = 1'b1;
        bus.Load   = load;
        bus.Target = target;
        @(posedge Clk);
        #1;
        bus.Start  = 1'b0;
        bus.Load   = 1'b0;
        bus.Target = 24'h999999;
        chk("busy_after_start", {31'd0, bus.Busy}, 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.Busy === 1'b1 && n < 3000) begin
            @(posedge Clk);
            #1;
            n++;
        end
        chk("op_finished", {31'd0, bus.Busy}, 32'd0);
    endtask

    task automatic wait_req(input int target_cnt);
        int n;
        n = 0;
        while (req_cnt < target_cnt && n < 500) begin
            @(negedge Clk);
            n++;
        end
        chk("req_reached", req_cnt, target_cnt);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (bus.CntReady !== 1'b1 && n < 100) begin
            @(posedge Clk);
            #1;
            n++;
        end
        chk("counter_ready", {31'd0, bus.CntReady}, 32'd1);
    endtask

    initial begin : main
        vecs[0] = '{"seek_up",   1'b0, 24'h000000, 24'h000012, 12, 1'b0, 24'h000012};
        vecs[1] = '{"seek_down", 1'b0, 24'h000105, 24'h000099,  6, 1'b1, 24'h000099};
        vecs[2] = '{"load",      1'b1, 24'h000042, 24'h123456,  1, 1'b0, 24'h123456};
        vecs[3] = '{"equal",     1'b0, 24'h000007, 24'h000007,  0, 1'b0, 24'h000007};
        vecs[4] = '{"carry_up",  1'b0, 24'h000009, 24'h000011,  2, 1'b0, 24'h000011};
        vecs[5] = '{"borrow_dn", 1'b0, 24'h000100, 24'h000098,  2, 1'b1, 24'h000098};
        vecs[6] = '{"top_down",  1'b0, 24'h999999, 24'h999997,  2, 1'b1, 24'h999997};

        Rst_n        = 1'b0;
        bus.Start    = 1'b0;
        bus.Load     = 1'b0;
        bus.Abort    = 1'b0;
        bus.Target   = '0;
        bus.CntOut   = '0;
        bus.CntReady = 1'b1;
        clear_counts();
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_busy",  {31'd0, bus.Busy},       32'd0);
        chk("rst_req",   {31'd0, bus.CntRequest}, 32'd0);
        chk("rst_dec",   {31'd0, bus.CntDec},     32'd0);
        chk("rst_set",   {31'd0, bus.CntSet},     32'd0);
        chk("rst_done",  {31'd0, bus.Done},       32'd0);
        chk("rst_cntin", {8'd0, bus.CntIn},       32'd0);
        chk("rst_steps", {16'd0, bus.StepCount},  32'd0);
        chk("rst_state", {29'd0, dbg_state},      32'd0);
        @(posedge Clk);
        #1 Rst_n = 1'b1;
        @(posedge Clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            bus.CntOut = vecs[i].cnt0;
            start_op(vecs[i].load, vecs[i].target);
            wait_idle();
            @(posedge Clk);
            #1;
            chk({vecs[i].name, "_req"},  req_cnt, vecs[i].exp_req);
            chk({vecs[i].name, "_set"},  set_cnt, vecs[i].load ? 1 : 0);
            if (!vecs[i].load)
                chk({vecs[i].name, "_dec"}, dec_cnt, vecs[i].exp_dec ? vecs[i].exp_req : 0);
            chk({vecs[i].name, "_steps"}, {16'd0, bus.StepCount},
                vecs[i].load ? 32'd0 : vecs[i].exp_req);
            chk({vecs[i].name, "_done"},  done_cnt, 1);
            chk({vecs[i].name, "_cnt"},   {8'd0, bus.CntOut}, {8'd0, vecs[i].exp_cnt});
            chk({vecs[i].name, "_cntin"}, {8'd0, bus.CntIn},  {8'd0, vecs[i].target});
            chk({vecs[i].name, "_setclr"}, {31'd0, bus.CntSet}, 32'd0);
            if (vecs[i].exp_req == 0)
                chk({vecs[i].name, "_done_lat"}, done_cyc - start_cyc, 2);
        end

        // Start during a seek must not disturb it
        bus.CntOut = 24'h000000;
        start_op(1'b0, 24'h000003);
        wait_req(1);
        @(posedge Clk);
        #1;
        bus.Start  = 1'b1;
        bus.Load   = 1'b1;
        bus.Target = 24'h000001;
        @(posedge Clk);
        #1;
        bus.Start  = 1'b0;
        bus.Load   = 1'b0;
        wait_idle();
        chk("busy_start_req",   req_cnt, 3);
        chk("busy_start_cnt",   {8'd0, bus.CntOut}, 32'h000003);
        chk("busy_start_cntin", {8'd0, bus.CntIn},  32'h000003);
        chk("busy_start_set",   set_cnt, 0);
        chk("busy_start_done",  done_cnt, 1);

        // Abort during the third step
        bus.CntOut = 24'h000000;
        start_op(1'b0, 24'h000050);
        wait_req(3);
        @(posedge Clk);
        #1 bus.Abort = 1'b1;
        @(posedge Clk);
        #1 bus.Abort = 1'b0;
        wait_idle();
        repeat (2) @(posedge Clk);
        #1;
        chk("abort_req",   req_cnt, 3);
        chk("abort_done",  done_cnt, 0);
        chk("abort_steps", {16'd0, bus.StepCount}, 32'd3);
        chk("abort_cnt",   {8'd0, bus.CntOut}, 32'h000003);
        chk("abort_state", {29'd0, dbg_state}, 32'd0);

        // Reset while waiting for the counter to acknowledge
        bus.CntOut = 24'h000000;
        start_op(1'b0, 24'h000050);
        wait_req(1);
        @(posedge Clk);
        #1;
        chk("mid_state_wait_ack", {29'd0, dbg_state}, 32'd3);
        Rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",  {31'd0, bus.Busy},       32'd0);
        chk("mid_rst_req",   {31'd0, bus.CntRequest}, 32'd0);
        chk("mid_rst_dec",   {31'd0, bus.CntDec},     32'd0);
        chk("mid_rst_set",   {31'd0, bus.CntSet},     32'd0);
        chk("mid_rst_done",  {31'd0, bus.Done},       32'd0);
        chk("mid_rst_cntin", {8'd0, bus.CntIn},       32'd0);
        chk("mid_rst_steps", {16'd0, bus.StepCount},  32'd0);
        @(posedge Clk);
        #1 Rst_n = 1'b1;
        wait_ready();
        repeat (2) @(posedge Clk);
        #1;
        chk("mid_rst_no_done", done_cnt, 0);
        chk("mid_rst_idle",    {31'd0, bus.Busy}, 32'd0);
        chk("mid_rst_cnt",     {8'd0, bus.CntOut}, 32'h000001);
        start_op(1'b0, 24'h000002);
        wait_idle();
        @(posedge Clk);
        #1;
        chk("post_rst_req",   req_cnt, 1);
        chk("post_rst_steps", {16'd0, bus.StepCount}, 32'd1);
        chk("post_rst_done",  done_cnt, 1);
        chk("post_rst_cnt",   {8'd0, bus.CntOut}, 32'h000002);
        chk("post_rst_cntin", {8'd0, bus.CntIn},  32'h000002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dekatron_seek_ctrl.md
DEKATRON_SEEK_CTRL -- requirements
Module: dekatron_seek_ctrl

Interface
REQ-001 The module SHALL have parameter D_NUM, default 6, setting the number of BCD decades driven on the counter.
REQ-002 Port Clk, input, 1: the single clock; all state updates SHALL occur on its rising edge.
REQ-003 Port Rst_n, input, 1: asynchronous, active-low reset.
REQ-004 Port Start, input, 1: one-cycle request to begin an operation; it SHALL be sampled only in IDLE.
REQ-005 Port Load, input, 1: sampled with Start; 1 = direct load, 0 = step-seek.
REQ-006 Port Abort, input, 1: terminates a seek at the next step boundary.
REQ-007 Port Target, input, D_NUM*4: BCD target value, LS decade in bits [3:0].
REQ-008 Port CntOut, input, D_NUM*4: the counter's current BCD value.
REQ-009 Port CntReady, input, 1: the counter is idle and accepts a request.
REQ-010 Port CntRequest, output, 1: one-cycle step or load request to the counter.
REQ-011 Port CntDec, output, 1: step direction, 1 = decrement; it SHALL be held stable from the CntRequest cycle until the matching CntReady rise.
REQ-012 Port CntSet, output, 1: marks the request as a load of CntIn.
REQ-013 Port CntIn, output, D_NUM*4: load value, equal to the latched target.
REQ-014 Port Busy, output, 1: high in every state except IDLE.
REQ-015 Port Done, output, 1: one-cycle pulse on successful completion.
REQ-016 Port StepCount, output, 16: number of step requests issued in the current or last operation.

Function
REQ-017 The FSM states SHALL be IDLE, COMPARE, ISSUE, WAIT_ACK, WAIT_DONE and FINISH.
REQ-018 IDLE with Start=1: latch Target into an internal target register, latch Load, clear StepCount, and go to COMPARE; Target is ignored after this cycle.
REQ-019 Start while Busy=1 SHALL be ignored.
REQ-020 COMPARE in load mode: set CntSet=1 and go to ISSUE.
REQ-021 COMPARE in seek mode: if CntOut equals the target, go to FINISH.
REQ-022 COMPARE in seek mode otherwise: set CntDec=1 if CntOut > target (unsigned compare of the packed BCD vector), else CntDec=0, and go to ISSUE; there is no wrap-around shortcut.
REQ-023 ISSUE: wait for CntReady=1, then drive CntRequest=1 for exactly one cycle and go to WAIT_ACK; StepCount SHALL increment (saturating at 16'hFFFF) only for a non-load request.
REQ-024 WAIT_ACK: wait for CntReady=0, then go to WAIT_DONE.
REQ-025 WAIT_DONE: wait for CntReady=1; then go to FINISH after a load, to IDLE if Abort was seen, otherwise to COMPARE.
REQ-026 Abort sampled high in any Busy state SHALL be remembered; the in-flight handshake always completes; Done SHALL NOT pulse for an aborted operation.
REQ-027 FINISH: pulse Done for one cycle, clear CntSet, and return to IDLE.
REQ-028 Each step SHALL take at least 4 cycles (COMPARE, ISSUE, WAIT_ACK, WAIT_DONE); no second CntRequest is issued before CntReady has fallen and risen again.
REQ-029 CntIn SHALL equal the latched target at all times after the first Start, and 0 before it.
REQ-030 A seek whose target is already equal to CntOut SHALL issue no request and pulse Done on the second cycle after Start.

Reset
REQ-031 When Rst_n=0, regardless of Clk, the module SHALL return to IDLE with CntRequest, CntDec, CntSet, Busy and Done at 0, and CntIn, StepCount, the target register and the abort flag cleared.
REQ-032 Reset mid-handshake SHALL abandon the operation with no Done pulse; the first Start after reset SHALL behave as from power-up.

Verification
REQ-033 Seek up: CntOut=000000, Target=000012, Start -> 12 requests with CntDec=0, StepCount=12, one Done, Busy falls.
REQ-034 Seek down: CntOut=000105, Target=000099 -> 6 requests with CntDec=1, Done, StepCount=6.
REQ-035 Load: Load=1, Target=123456 -> exactly one CntRequest with CntSet=1 and CntIn=123456, StepCount=0, Done.
REQ-036 Equal target: CntOut=Target=000007 -> no CntRequest, Done on cycle 2 after Start.
REQ-037 Abort: Abort raised during the 3rd step of a seek to 000050 -> the 3rd handshake completes, no Done, IDLE, StepCount=3.
REQ-038 Reset in WAIT_ACK: Rst_n low for one cycle -> all outputs 0 immediately; a following Start to 000002 completes normally.
